// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
package regfile_pkg;

  // Default geometry of the register file.
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;
  localparam int NRD_DEF    = 2;

  // Write-port indices: ALU writeback and load writeback.
  localparam int WP_ALU  = 0;
  localparam int WP_LOAD = 1;
  localparam int NWP     = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for pending loads: owns the per-register busy bits,
// the reserve/clear priority, the double-reservation error pulse and the
// (optionally bypassed) per-read-port busy flags.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWP-1:0]          wr_en_i,
  input  logic [NWP*ADDR_W-1:0]   wr_addr_i,
  input  logic                    reserve_i,
  input  logic [ADDR_W-1:0]       res_addr_i,
  input  logic [NRD*ADDR_W-1:0]   rd_addr_i,
  output logic [NRD-1:0]          rd_busy_o,
  output logic [(2**ADDR_W)-1:0]  busy_o,
  output logic                    res_err_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              res_err_q;
  logic              res_err_d;
  logic [ADDR_W-1:0] wa_alu_s;
  logic [ADDR_W-1:0] wa_load_s;
  logic              res_ok_s;
  logic              res_clr_s;

  assign wa_alu_s  = wr_addr_i[WP_ALU*ADDR_W +: ADDR_W];
  assign wa_load_s = wr_addr_i[WP_LOAD*ADDR_W +: ADDR_W];

  // Reservation qualification: the hard-wired zero register can never be reserved.
  always_comb begin
    res_ok_s  = 1'b0;
    res_clr_s = 1'b0;
    if ((ZERO_REG != 0) && (res_addr_i == '0)) begin
      res_ok_s = 1'b0;
    end else begin
      res_ok_s = reserve_i;
    end
    res_clr_s = (wr_en_i[WP_ALU]  && (wa_alu_s  == res_addr_i)) ||
                (wr_en_i[WP_LOAD] && (wa_load_s == res_addr_i));
  end

  // Next busy state: a new reservation beats a clearing write; error on re-reserve of a still-busy register.
  always_comb begin
    busy_d    = busy_q;
    res_err_d = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if ((ZERO_REG != 0) && (r == 0)) begin
        busy_d[r] = 1'b0;
      end else if (res_ok_s && (res_addr_i == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((wr_en_i[WP_ALU]  && (wa_alu_s  == ADDR_W'(r))) ||
                   (wr_en_i[WP_LOAD] && (wa_load_s == ADDR_W'(r)))) begin
        busy_d[r] = 1'b0;
      end else begin
        busy_d[r] = busy_q[r];
      end
    end
    if (res_ok_s && busy_q[res_addr_i] && !res_clr_s) begin
      res_err_d = 1'b1;
    end else begin
      res_err_d = 1'b0;
    end
  end

  // Busy bits and error pulse register; reset discards same-cycle reservations.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      res_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      res_err_q <= res_err_d;
    end
  end

  // Per-read-port busy flag; with bypass a same-cycle write hides the pending load.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    ra        = '0;
    hit       = 1'b0;
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      ra  = rd_addr_i[i*ADDR_W +: ADDR_W];
      hit = (BYPASS != 0) &&
            ((wr_en_i[WP_ALU]  && (wa_alu_s  == ra)) ||
             (wr_en_i[WP_LOAD] && (wa_load_s == ra)));
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_busy_o[i] = 1'b0;
      end else begin
        rd_busy_o[i] = busy_q[ra] & ~hit;
      end
    end
  end

  assign busy_o    = busy_q;
  assign res_err_o = res_err_q;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised register file with NRD read ports, ALU and load write ports,
// optional write-to-read bypass, optional zero register and a load scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   RdAddr,
  output logic [NRD*DATA_W-1:0]   RdData,
  output logic [NRD-1:0]          RdBusy,
  input  logic [1:0]              WrEn,
  input  logic [2*ADDR_W-1:0]     WrAddr,
  input  logic [2*DATA_W-1:0]     WrData,
  input  logic                    Reserve,
  input  logic [ADDR_W-1:0]       ResAddr,
  output logic [(2**ADDR_W)-1:0]  BusyVec,
  output logic                    WrConflict,
  output logic                    ResErr
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              conf_q;
  logic              conf_d;
  logic [ADDR_W-1:0] wa_alu_s;
  logic [ADDR_W-1:0] wa_load_s;
  logic [DATA_W-1:0] wd_alu_s;
  logic [DATA_W-1:0] wd_load_s;
  logic [NRD*DATA_W-1:0] rd_data_s;

  assign wa_alu_s  = WrAddr[WP_ALU*ADDR_W +: ADDR_W];
  assign wa_load_s = WrAddr[WP_LOAD*ADDR_W +: ADDR_W];
  assign wd_alu_s  = WrData[WP_ALU*DATA_W +: DATA_W];
  assign wd_load_s = WrData[WP_LOAD*DATA_W +: DATA_W];

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (WrEn),
    .wr_addr_i  (WrAddr),
    .reserve_i  (Reserve),
    .res_addr_i (ResAddr),
    .rd_addr_i  (RdAddr),
    .rd_busy_o  (RdBusy),
    .busy_o     (BusyVec),
    .res_err_o  (ResErr)
  );

  // Next array contents: load port wins over ALU on an address clash; register 0 pinned when hard-wired.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
      if ((ZERO_REG != 0) && (r == 0)) begin
        mem_d[r] = '0;
      end else if (WrEn[WP_LOAD] && (wa_load_s == ADDR_W'(r))) begin
        mem_d[r] = wd_load_s;
      end else if (WrEn[WP_ALU] && (wa_alu_s == ADDR_W'(r))) begin
        mem_d[r] = wd_alu_s;
      end else begin
        mem_d[r] = mem_q[r];
      end
    end
  end

  // Dual-write clash detection (never for the hard-wired zero register).
  always_comb begin
    conf_d = 1'b0;
    if (WrEn[WP_ALU] && WrEn[WP_LOAD] && (wa_alu_s == wa_load_s) &&
        !((ZERO_REG != 0) && (wa_alu_s == '0))) begin
      conf_d = 1'b1;
    end else begin
      conf_d = 1'b0;
    end
  end

  // Storage array and conflict pulse register; writes in the reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      conf_q <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      conf_q <= conf_d;
    end
  end

  // Read muxes: zero register, then bypassed write data (load first), then array.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] word;
    ra        = '0;
    word      = '0;
    rd_data_s = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = RdAddr[i*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (ra == '0)) begin
        word = '0;
      end else if ((BYPASS != 0) && WrEn[WP_LOAD] && (wa_load_s == ra)) begin
        word = wd_load_s;
      end else if ((BYPASS != 0) && WrEn[WP_ALU] && (wa_alu_s == ra)) begin
        word = wd_alu_s;
      end else begin
        word = mem_q[ra];
      end
      rd_data_s[i*DATA_W +: DATA_W] = word;
    end
  end

  assign RdData     = rd_data_s;
  assign WrConflict = conf_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: three register files (bypass, no bypass, bypass + zero
// register) share the same stimulus and are compared against a behavioural model.
module tb_register_file_mp;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int NR   = 2;
  localparam int NCFG = 3;
  localparam int DEP  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NR*AW-1:0]   rd_addr;
  logic [1:0]         wr_en;
  logic [2*AW-1:0]    wr_addr;
  logic [2*DW-1:0]    wr_data;
  logic               reserve;
  logic [AW-1:0]      res_addr;

  logic [NR*DW-1:0]   rd_data  [NCFG];
  logic [NR-1:0]      rd_busy  [NCFG];
  logic [DEP-1:0]     busy_vec [NCFG];
  logic               wr_conf  [NCFG];
  logic               res_err  [NCFG];

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_REG(0)) u_byp (
    .clk(clk), .rst(rst), .RdAddr(rd_addr), .RdData(rd_data[0]), .RdBusy(rd_busy[0]),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .Reserve(reserve), .ResAddr(res_addr),
    .BusyVec(busy_vec[0]), .WrConflict(wr_conf[0]), .ResErr(res_err[0]));

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
    .clk(clk), .rst(rst), .RdAddr(rd_addr), .RdData(rd_data[1]), .RdBusy(rd_busy[1]),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .Reserve(reserve), .ResAddr(res_addr),
    .BusyVec(busy_vec[1]), .WrConflict(wr_conf[1]), .ResErr(res_err[1]));

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .BYPASS(1), .ZERO_REG(1)) u_zero (
    .clk(clk), .rst(rst), .RdAddr(rd_addr), .RdData(rd_data[2]), .RdBusy(rd_busy[2]),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .Reserve(reserve), .ResAddr(res_addr),
    .BusyVec(busy_vec[2]), .WrConflict(wr_conf[2]), .ResErr(res_err[2]));

  int total = 0;
  int bad   = 0;

  int cfg_bp [NCFG] = '{1, 0, 1};
  int cfg_zr [NCFG] = '{0, 0, 1};

  // Behavioural model state per configuration
  logic [DW-1:0] m_mem  [NCFG][DEP];
  bit            m_busy [NCFG][DEP];
  bit            m_conf [NCFG];
  bit            m_rerr [NCFG];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] we,
                       input logic [3:0] a0, input logic [31:0] d0,
                       input logic [3:0] a1, input logic [31:0] d1,
                       input logic res, input logic [3:0] ra,
                       input logic [3:0] q0, input logic [3:0] q1);
    rst      = r;
    wr_en    = we;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    reserve  = res;
    res_addr = ra;
    rd_addr  = {q1, q0};
  endtask

  function automatic logic [3:0] wa(input int p);
    logic [2*AW-1:0] v;
    v = wr_addr;
    return v[p*AW +: AW];
  endfunction

  function automatic logic [31:0] wd(input int p);
    logic [2*DW-1:0] v;
    v = wr_data;
    return v[p*DW +: DW];
  endfunction

  function automatic logic [31:0] exp_read(input int k, input logic [3:0] a);
    if (cfg_zr[k] == 1 && a == 4'd0) return 32'd0;
    if (cfg_bp[k] == 1 && wr_en[1] && wa(1) == a) return wd(1);
    if (cfg_bp[k] == 1 && wr_en[0] && wa(0) == a) return wd(0);
    return m_mem[k][a];
  endfunction

  function automatic logic exp_rbusy(input int k, input logic [3:0] a);
    bit hit;
    if (cfg_zr[k] == 1 && a == 4'd0) return 1'b0;
    hit = (wr_en[0] && wa(0) == a) || (wr_en[1] && wa(1) == a);
    if (cfg_bp[k] == 1 && hit) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic check_all(input string ph);
    logic [3:0]     a;
    logic [DEP-1:0] bv;
    for (int k = 0; k < NCFG; k++) begin
      for (int i = 0; i < NR; i++) begin
        a = rd_addr[i*AW +: AW];
        check($sformatf("%s.c%0d.rdata%0d", ph, k, i), 64'(rd_data[k][i*DW +: DW]), 64'(exp_read(k, a)));
        check($sformatf("%s.c%0d.rbusy%0d", ph, k, i), 64'(rd_busy[k][i]), 64'(exp_rbusy(k, a)));
      end
      for (int r = 0; r < DEP; r++) bv[r] = m_busy[k][r];
      check($sformatf("%s.c%0d.busyvec", ph, k), 64'(busy_vec[k]), 64'(bv));
      check($sformatf("%s.c%0d.wrconf", ph, k), 64'(wr_conf[k]), 64'(m_conf[k]));
      check($sformatf("%s.c%0d.reserr", ph, k), 64'(res_err[k]), 64'(m_rerr[k]));
    end
  endtask

  // Apply the register-file rules for one clock edge to the model
  task automatic model_edge();
    bit zr0, clr;
    for (int k = 0; k < NCFG; k++) begin
      if (rst) begin
        for (int r = 0; r < DEP; r++) begin
          m_mem[k][r]  = 32'd0;
          m_busy[k][r] = 1'b0;
        end
        m_conf[k] = 1'b0;
        m_rerr[k] = 1'b0;
      end else begin
        m_conf[k] = wr_en[0] && wr_en[1] && wa(0) == wa(1) && !(cfg_zr[k] == 1 && wa(0) == 4'd0);
        zr0 = (cfg_zr[k] == 1 && res_addr == 4'd0);
        clr = (wr_en[0] && wa(0) == res_addr) || (wr_en[1] && wa(1) == res_addr);
        m_rerr[k] = reserve && !zr0 && m_busy[k][res_addr] && !clr;
        for (int p = 0; p < 2; p++) begin
          if (wr_en[p] && !(cfg_zr[k] == 1 && wa(p) == 4'd0)) begin
            m_mem[k][wa(p)]  = wd(p);
            m_busy[k][wa(p)] = 1'b0;
          end
        end
        if (reserve && !zr0) m_busy[k][res_addr] = 1'b1;
      end
    end
  endtask

  task automatic settle(input string ph);
    #1;
    check_all(ph);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    // Reset cycle with no checks (state before first reset is undefined)
    drive(1'b1, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();

    // ALU write reg2 = 0xF, then read it back
    drive(1'b0, 2'b01, 4'd2, 32'h0000000F, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 4'd4);
    settle("wr2");
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd2, 4'd1);
    settle("rd2");
    check("rd2.lit", 64'(rd_data[1][31:0]), 64'h0000000F);
    check("busy0.lit", 64'(busy_vec[0]), 64'h0);
    tick();

    // Bypass: write reg7 and read it in the same cycle
    drive(1'b0, 2'b01, 4'd7, 32'hDEADBEEF, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd2);
    settle("byp");
    check("byp.lit", 64'(rd_data[0][31:0]), 64'hDEADBEEF);
    check("nobyp.old", 64'(rd_data[1][31:0]), 64'h0);
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd7, 4'd7);
    settle("byp2");
    check("nobyp.new", 64'(rd_data[1][31:0]), 64'hDEADBEEF);
    tick();

    // Dual write conflict on reg5
    drive(1'b0, 2'b11, 4'd5, 32'h11, 4'd5, 32'h22, 1'b0, 4'd0, 4'd5, 4'd0);
    settle("conf");
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd5, 4'd0);
    settle("conf1");
    check("conf.pulse", 64'(wr_conf[1]), 64'h1);
    check("conf.val", 64'(rd_data[1][31:0]), 64'h22);
    tick();
    settle("conf2");
    tick();

    // Scoreboard: reserve reg3, clear it with a load write, then double reserve
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd3, 4'd1);
    settle("res");
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 4'd3);
    settle("res.busy");
    check("res.rbusy", 64'(rd_busy[0][0]), 64'h1);
    tick();
    drive(1'b0, 2'b10, 4'd0, 32'd0, 4'd3, 32'h55, 1'b0, 4'd0, 4'd3, 4'd0);
    settle("ld3");
    check("ld3.rbusy.byp", 64'(rd_busy[0][0]), 64'h0);
    check("ld3.rdata.byp", 64'(rd_data[0][31:0]), 64'h55);
    check("ld3.rbusy.nobyp", 64'(rd_busy[1][0]), 64'h1);
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd3, 4'd0);
    settle("rr1");
    tick();
    settle("rr2");
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd3, 4'd0);
    settle("rr3");
    check("reserr.pulse", 64'(res_err[0]), 64'h1);
    tick();
    settle("rr4");
    tick();

    // Zero register: write and reserve reg0, then reserve it again
    drive(1'b0, 2'b01, 4'd0, 32'h0000FFFF, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0, 4'd0);
    settle("z0");
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0, 4'd0);
    settle("z1");
    check("zero.rdata", 64'(rd_data[2][31:0]), 64'h0);
    check("zero.busy0", 64'(busy_vec[2][0]), 64'h0);
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0, 4'd0);
    settle("z2");
    check("zero.reserr", 64'(res_err[2]), 64'h0);
    tick();

    // Reset mid-operation with a write and reservation of reg9
    drive(1'b0, 2'b01, 4'd9, 32'h99, 4'd0, 32'd0, 1'b1, 4'd9, 4'd9, 4'd0);
    settle("pre9");
    tick();
    drive(1'b1, 2'b01, 4'd9, 32'h1234, 4'd0, 32'd0, 1'b1, 4'd9, 4'd9, 4'd7);
    settle("rst9");
    tick();
    drive(1'b0, 2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd9, 4'd7);
    settle("post9");
    check("post9.rdata", 64'(rd_data[1][31:0]), 64'h0);
    check("post9.busy", 64'(busy_vec[0]), 64'h0);
    tick();

    // Randomised traffic on a narrow address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 7)), $urandom,
            4'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 7)),
            4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
      settle("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
